// File: rtl/spmv_csr_sequencer_pkg.sv
// rtl/spmv_csr_sequencer_pkg.sv - shared widths, core state codes and sequencer states
package spmv_pkg;
   localparam int DATA_W = 16;
   localparam int IDX_W  = 8;
   localparam int COL_W  = 4;

   typedef enum logic [2:0] {
      CORE_IDLE  = 3'd0,
      CORE_MUL   = 3'd1,
      CORE_ADD   = 3'd2,
      CORE_WRITE = 3'd3,
      CORE_DONE  = 3'd4
   } core_state_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRIME_VC,
      S_PRIME_VEC,
      S_LAUNCH,
      S_RUN,
      S_FINISH
   } seq_state_e;
endpackage

// File: rtl/spmv_csr_sequencer_if.sv
// rtl/spmv_csr_sequencer_if.sv - memory read ports and SpMV_core operand/handshake bundle
interface spmv_csr_sequencer_if;
   import spmv_pkg::*;

   logic [IDX_W-1:0]  o_val_addr;
   logic [IDX_W-1:0]  o_col_addr;
   logic              o_vc_en;
   logic [DATA_W-1:0] i_val_data;
   logic [COL_W-1:0]  i_col_data;
   logic [COL_W-1:0]  o_vec_addr;
   logic              o_vec_en;
   logic [DATA_W-1:0] i_vec_data;
   logic              o_core_start;
   logic [DATA_W-1:0] o_mat_value;
   logic [DATA_W-1:0] o_in_vector;
   logic [IDX_W-1:0]  o_count;
   logic [2:0]        i_core_state;

   modport master (
      output o_val_addr, o_col_addr, o_vc_en, o_vec_addr, o_vec_en,
      output o_core_start, o_mat_value, o_in_vector, o_count,
      input  i_val_data, i_col_data, i_vec_data, i_core_state
   );

   modport slave (
      input  o_val_addr, o_col_addr, o_vc_en, o_vec_addr, o_vec_en,
      input  o_core_start, o_mat_value, o_in_vector, o_count,
      output i_val_data, i_col_data, i_vec_data, i_core_state
   );
endinterface

// File: rtl/spmv_csr_sequencer_prefetch.sv
// rtl/spmv_csr_sequencer_prefetch.sv - spmv_operand_prefetch: read issue, val_hold and core operand registers
module spmv_operand_prefetch
   import spmv_pkg::*;
(
   input  logic              clk,
   input  logic              rstn,
   input  logic              prime_vc,
   input  logic              prime_vec,
   input  logic              launch,
   input  logic              run_mul,
   input  logic              run_add,
   input  logic              run_write,
   input  logic              pending,
   input  logic [IDX_W-1:0]  next_idx,
   input  logic [DATA_W-1:0] val_data,
   input  logic [COL_W-1:0]  col_data,
   input  logic [DATA_W-1:0] vec_data,
   output logic              vc_en,
   output logic [IDX_W-1:0]  val_addr,
   output logic [IDX_W-1:0]  col_addr,
   output logic              vec_en,
   output logic [COL_W-1:0]  vec_addr,
   output logic [DATA_W-1:0] mat_value,
   output logic [DATA_W-1:0] in_vector
);
   logic [DATA_W-1:0] val_hold;
   logic              rd_next;
   logic              load_ops;

   // Prefetch of k+1 only happens while the core is working on k and k+1 exists.
   assign rd_next  = run_mul & pending;
   assign vc_en    = prime_vc | rd_next;
   assign val_addr = rd_next ? next_idx : '0;
   assign col_addr = val_addr;
   assign vec_en   = prime_vec | (run_add & pending);
   assign vec_addr = vec_en ? col_data : '0;
   assign load_ops = launch | (run_write & pending);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         val_hold  <= '0;
         mat_value <= '0;
         in_vector <= '0;
      end else begin
         if (vec_en) val_hold <= val_data;
         if (load_ops) begin
            mat_value <= val_hold;
            in_vector <= vec_data;
         end
      end
   end
endmodule

// File: rtl/spmv_csr_sequencer.sv
// rtl/spmv_csr_sequencer.sv - sequences one SpMV_core pass over a CSR matrix with operand prefetch
module spmv_csr_sequencer
   import spmv_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_go,
   input  logic [IDX_W-1:0] i_nnz,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err,
   spmv_csr_sequencer_if.master bus
);
   seq_state_e       state;
   logic [IDX_W-1:0] nnz_q;
   logic [IDX_W-1:0] k_q;
   logic [IDX_W-1:0] count_q;
   logic             start_q;
   logic [IDX_W:0]   k_next;
   logic             pending;
   logic             in_run;

   assign k_next  = {1'b0, k_q} + 1'b1;
   assign pending = k_next < {1'b0, nnz_q};
   assign in_run  = (state == S_RUN);

   assign bus.o_core_start = start_q;
   assign bus.o_count      = count_q;

   spmv_operand_prefetch u_prefetch (
      .clk       (i_clk),
      .rstn      (i_rstn),
      .prime_vc  (state == S_PRIME_VC),
      .prime_vec (state == S_PRIME_VEC),
      .launch    (state == S_LAUNCH),
      .run_mul   (in_run && bus.i_core_state == CORE_MUL),
      .run_add   (in_run && bus.i_core_state == CORE_ADD),
      .run_write (in_run && bus.i_core_state == CORE_WRITE),
      .pending   (pending),
      .next_idx  (k_next[IDX_W-1:0]),
      .val_data  (bus.i_val_data),
      .col_data  (bus.i_col_data),
      .vec_data  (bus.i_vec_data),
      .vc_en     (bus.o_vc_en),
      .val_addr  (bus.o_val_addr),
      .col_addr  (bus.o_col_addr),
      .vec_en    (bus.o_vec_en),
      .vec_addr  (bus.o_vec_addr),
      .mat_value (bus.o_mat_value),
      .in_vector (bus.o_in_vector)
   );

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state   <= S_IDLE;
         nnz_q   <= '0;
         k_q     <= '0;
         count_q <= '0;
         start_q <= 1'b0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
         o_err   <= 1'b0;
      end else begin
         start_q <= 1'b0;
         o_done  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_go) begin
                  nnz_q   <= i_nnz;
                  k_q     <= '0;
                  count_q <= '0;
                  o_err   <= 1'b0;
                  if (i_nnz == '0) begin
                     state <= S_FINISH;
                  end else begin
                     state  <= S_PRIME_VC;
                     o_busy <= 1'b1;
                  end
               end
            end
            S_PRIME_VC:  state <= S_PRIME_VEC;
            S_PRIME_VEC: begin
               state   <= S_LAUNCH;
               start_q <= 1'b1;
            end
            S_LAUNCH:    state <= S_RUN;
            S_RUN: begin
               // count leads k by the ADD->WRITE edge so the core sees k+1 in WRITE
               if (bus.i_core_state == CORE_ADD) begin
                  count_q <= count_q + 1'b1;
               end else if (bus.i_core_state == CORE_WRITE) begin
                  k_q <= k_next[IDX_W-1:0];
               end else if (bus.i_core_state == CORE_DONE) begin
                  state <= S_FINISH;
                  if (count_q != nnz_q) o_err <= 1'b1;
               end
            end
            S_FINISH: begin
               o_done <= 1'b1;
               o_busy <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spmv_csr_sequencer.sv
// tb/tb_spmv_csr_sequencer.sv - directed self-checking bench with memory and SpMV_core models
module tb_spmv_csr_sequencer;
   import spmv_pkg::*;

   logic             clk = 1'b0;
   logic             i_rstn;
   logic             i_go;
   logic [IDX_W-1:0] i_nnz;
   logic             o_busy, o_done, o_err;

   spmv_csr_sequencer_if bus ();

   spmv_csr_sequencer dut (
      .i_clk  (clk),
      .i_rstn (i_rstn),
      .i_go   (i_go),
      .i_nnz  (i_nnz),
      .o_busy (o_busy),
      .o_done (o_done),
      .o_err  (o_err),
      .bus    (bus.master)
   );

   always #5 clk = ~clk;

   logic [DATA_W-1:0] val_mem [0:255];
   logic [COL_W-1:0]  col_mem [0:255];
   logic [DATA_W-1:0] vec_mem [0:15];

   always @(posedge clk) begin
      if (bus.o_vc_en) begin
         bus.i_val_data <= val_mem[bus.o_val_addr];
         bus.i_col_data <= col_mem[bus.o_col_addr];
      end
      if (bus.o_vec_en) bus.i_vec_data <= vec_mem[bus.o_vec_addr];
   end

   logic [2:0] core_st;
   int         core_total;
   always @(posedge clk or negedge i_rstn) begin
      if (!i_rstn) core_st <= 3'd0;
      else case (core_st)
         3'd0: if (bus.o_core_start) core_st <= 3'd1;
         3'd1: core_st <= 3'd2;
         3'd2: core_st <= 3'd3;
         3'd3: core_st <= (int'(bus.o_count) >= core_total) ? 3'd4 : 3'd1;
         default: core_st <= 3'd0;
      endcase
   end
   assign bus.i_core_state = core_st;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int starts, dones, start_cyc, done_cyc, vc_cnt, vec_cnt, both_cnt, unstable, gaps, go_cyc;
   logic [2:0]        prev_st;
   logic [COL_W-1:0]  vaddr_q [$];
   logic [IDX_W-1:0]  cnt_q [$];
   logic [DATA_W-1:0] mat_q [$];
   logic [DATA_W-1:0] inv_q [$];

   always @(negedge clk) begin
      if (bus.o_core_start) begin starts++; start_cyc = cyc; end
      if (o_done) begin dones++; done_cyc = cyc; end
      if (bus.o_vc_en) vc_cnt++;
      if (bus.o_vec_en) begin vec_cnt++; vaddr_q.push_back(bus.o_vec_addr); end
      if (bus.o_vc_en && bus.o_vec_en) both_cnt++;
      if (core_st == 3'd1) begin
         mat_q.push_back(bus.o_mat_value);
         inv_q.push_back(bus.o_in_vector);
      end else if (core_st == 3'd2) begin
         if (mat_q.size() > 0 && (bus.o_mat_value !== mat_q[$] || bus.o_in_vector !== inv_q[$])) unstable++;
      end else if (core_st == 3'd3) begin
         cnt_q.push_back(bus.o_count);
      end
      if (prev_st == 3'd3 && core_st != 3'd1 && core_st != 3'd4) gaps++;
      prev_st = core_st;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic clear_mon();
      starts = 0; dones = 0; start_cyc = 0; done_cyc = 0; vc_cnt = 0; vec_cnt = 0;
      both_cnt = 0; unstable = 0; gaps = 0;
      vaddr_q.delete(); cnt_q.delete(); mat_q.delete(); inv_q.delete();
   endtask

   task automatic start_pass(input int n, input int total);
      @(posedge clk); #1;
      clear_mon();
      core_total = total;
      @(negedge clk);
      i_nnz  = IDX_W'(n);
      i_go   = 1'b1;
      go_cyc = cyc;
      @(negedge clk);
      i_go = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int i = 0;
      while (dones == 0 && i < 300) begin @(negedge clk); i++; end
      check({tag, "_done_seen"}, dones != 0, 1);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin val_mem[i] = '0; col_mem[i] = '0; end
      for (int j = 0; j < 16; j++) vec_mem[j] = 16'h1000 + 16'(j);
      vec_mem[2] = 16'h4000;
      val_mem[0] = 16'h3C00; col_mem[0] = 4'd2;
      i_rstn = 1'b0; i_go = 1'b0; i_nnz = '0; core_total = 0; prev_st = 3'd0;
      clear_mon();
      repeat (2) @(negedge clk);
      check("rst_outs", {o_busy, o_done, o_err, bus.o_vc_en, bus.o_vec_en, bus.o_core_start}, 0);
      check("rst_data", {bus.o_count, bus.o_mat_value, bus.o_in_vector, bus.o_val_addr, bus.o_vec_addr}, 0);
      i_rstn = 1'b1;
      repeat (2) @(negedge clk);

      // single nonzero: 1.0 * vec[2]
      start_pass(1, 1);
      check("t1_busy", o_busy, 1);
      wait_done("t1");
      check("t1_starts", starts, 1);
      check("t1_start_lat", start_cyc - go_cyc, 3);
      check("t1_mat", mat_q.size() > 0 ? mat_q[0] : 16'hxxxx, 16'h3C00);
      check("t1_vec", inv_q.size() > 0 ? inv_q[0] : 16'hxxxx, 16'h4000);
      check("t1_unstable", unstable, 0);
      check("t1_count_wr", cnt_q.size() > 0 ? cnt_q[0] : 8'hxx, 1);
      check("t1_done_lat", done_cyc - go_cyc, 9);
      check("t1_err", o_err, 0);
      @(negedge clk);
      check("t1_busy_end", o_busy, 0);

      // four nonzeros, repeated and extreme columns
      val_mem[1] = 16'h4000; val_mem[2] = 16'h4200; val_mem[3] = 16'h4400;
      col_mem[0] = 4'd0; col_mem[1] = 4'd3; col_mem[2] = 4'd3; col_mem[3] = 4'd15;
      start_pass(4, 4);
      wait_done("t2");
      check("t2_vaddr_n", vaddr_q.size(), 4);
      if (vaddr_q.size() == 4) check("t2_vaddr", {vaddr_q[0], vaddr_q[1], vaddr_q[2], vaddr_q[3]}, 16'h033F);
      check("t2_cnt_n", cnt_q.size(), 4);
      if (cnt_q.size() == 4) check("t2_counts", {cnt_q[0], cnt_q[1], cnt_q[2], cnt_q[3]}, 32'h01020304);
      if (mat_q.size() == 4) begin
         check("t2_mats", {mat_q[1], mat_q[3]}, 32'h40004400);
         check("t2_vecs", {inv_q[0], inv_q[1], inv_q[2], inv_q[3]}, 64'h100010031003100F);
      end
      check("t2_gaps", gaps, 0);
      check("t2_vc_cnt", vc_cnt, 4);
      check("t2_both_en", both_cnt, 0);
      check("t2_unstable", unstable, 0);
      check("t2_done_lat", done_cyc - go_cyc, 18);
      check("t2_count_held", bus.o_count, 4);

      // empty matrix
      start_pass(0, 0);
      wait_done("t3");
      check("t3_done_lat", done_cyc - go_cyc, 2);
      check("t3_starts", starts, 0);
      check("t3_mem_en", vc_cnt + vec_cnt, 0);
      check("t3_count", bus.o_count, 0);

      // second go while busy must be ignored
      start_pass(4, 4);
      repeat (4) @(negedge clk);
      i_nnz = 8'd7; i_go = 1'b1;
      @(negedge clk);
      i_go = 1'b0;
      wait_done("t4");
      repeat (25) @(negedge clk);
      check("t4_dones", dones, 1);
      check("t4_done_lat", done_cyc - go_cyc, 18);
      check("t4_err", o_err, 0);
      check("t4_vc_cnt", vc_cnt, 4);

      // core stops early: count mismatch flags error
      start_pass(3, 2);
      wait_done("t5");
      check("t5_err", o_err, 1);
      check("t5_dones", dones, 1);
      check("t5_done_lat", done_cyc - go_cyc, 12);
      repeat (5) @(negedge clk);
      check("t5_err_sticky", o_err, 1);
      start_pass(1, 1);
      check("t5_err_clr", o_err, 0);
      wait_done("t5b");
      check("t5b_err", o_err, 0);

      // asynchronous reset in the middle of element k=2
      start_pass(4, 4);
      while (cyc < go_cyc + 11) @(negedge clk);
      check("t6_core_add", core_st, 3'd2);
      check("t6_count_k2", bus.o_count, 2);
      i_rstn = 1'b0;
      #1;
      check("t6_rst_outs", {o_busy, o_done, o_err, bus.o_vc_en, bus.o_vec_en, bus.o_core_start}, 0);
      check("t6_rst_data", {bus.o_count, bus.o_mat_value, bus.o_in_vector, bus.o_val_addr, bus.o_vec_addr}, 0);
      @(negedge clk);
      i_rstn = 1'b1;
      @(negedge clk);
      start_pass(2, 2);
      wait_done("t6");
      check("t6_done_lat", done_cyc - go_cyc, 12);
      check("t6_err", o_err, 0);
      if (cnt_q.size() == 2) check("t6_counts", {cnt_q[0], cnt_q[1]}, 16'h0102);
      else check("t6_cnt_n", cnt_q.size(), 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
